// File: rtl/coherence_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// coherence_bus_arbiter_if : request/grant bundle between the cache
// controllers, the bus FSM and the coherence bus arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface coherence_bus_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              req_0;
  logic [1:0]        op_0;
  logic [ADDR_W-1:0] addr_0;
  logic              req_1;
  logic [1:0]        op_1;
  logic [ADDR_W-1:0] addr_1;
  logic              done;

  logic              gnt_0;
  logic              gnt_1;
  logic              bus_valid;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_owner;
  logic              timeout_err;

  // Requesters and the bus FSM drive the inputs and observe the grant side.
  modport master (
    output req_0, op_0, addr_0, req_1, op_1, addr_1, done,
    input  gnt_0, gnt_1, bus_valid, bus_op, bus_addr, bus_owner, timeout_err
  );

  modport slave (
    input  req_0, op_0, addr_0, req_1, op_1, addr_1, done,
    output gnt_0, gnt_1, bus_valid, bus_op, bus_addr, bus_owner, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/coherence_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// coherence_bus_arbiter : round-robin owner selection for the snooping bus,
// with latched op/address and a watchdog-forced release.
// Revision: 1.0
// ---------------------------------------------------------------------------
module coherence_bus_arbiter #(
  parameter int ADDR_W      = 13,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  coherence_bus_arbiter_if.slave bus_io
);

  localparam int              WD_W         = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] C_WD_MAX     = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]      C_OP_ILLEGAL = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e            state_q;
  logic              ptr_q;
  logic [WD_W-1:0]   wd_q;
  logic              gnt_0_q;
  logic              gnt_1_q;
  logic              valid_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              owner_q;
  logic              tmo_q;

  logic w_elig_0;
  logic w_elig_1;
  logic w_win_1;

  assign w_elig_0 = bus_io.req_0 && (bus_io.op_0 != C_OP_ILLEGAL);
  assign w_elig_1 = bus_io.req_1 && (bus_io.op_1 != C_OP_ILLEGAL);
  // cpu1 wins when it is alone, or when both contend and the pointer names it.
  assign w_win_1  = w_elig_1 && (!w_elig_0 || ptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      wd_q    <= '0;
      gnt_0_q <= 1'b0;
      gnt_1_q <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      owner_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          wd_q <= '0;
          if (w_elig_0 || w_elig_1) begin
            state_q <= S_BUSY;
            gnt_0_q <= !w_win_1;
            gnt_1_q <= w_win_1;
            valid_q <= 1'b1;
            owner_q <= w_win_1;
            op_q    <= w_win_1 ? bus_io.op_1   : bus_io.op_0;
            addr_q  <= w_win_1 ? bus_io.addr_1 : bus_io.addr_0;
          end else begin
            gnt_0_q <= 1'b0;
            gnt_1_q <= 1'b0;
            valid_q <= 1'b0;
            owner_q <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
          end
        end

        S_BUSY: begin
          // done takes precedence over a simultaneous watchdog expiry.
          if (bus_io.done || (wd_q == C_WD_MAX)) begin
            state_q <= S_RELEASE;
            tmo_q   <= !bus_io.done;
            ptr_q   <= !owner_q;
            gnt_0_q <= 1'b0;
            gnt_1_q <= 1'b0;
            valid_q <= 1'b0;
            owner_q <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end

        S_RELEASE: begin
          state_q <= S_IDLE;
          wd_q    <= '0;
        end

        default: begin
          state_q <= S_IDLE;
          gnt_0_q <= 1'b0;
          gnt_1_q <= 1'b0;
          valid_q <= 1'b0;
          wd_q    <= '0;
        end
      endcase
    end
  end

  assign bus_io.gnt_0       = gnt_0_q;
  assign bus_io.gnt_1       = gnt_1_q;
  assign bus_io.bus_valid   = valid_q;
  assign bus_io.bus_op      = op_q;
  assign bus_io.bus_addr    = addr_q;
  assign bus_io.bus_owner   = owner_q;
  assign bus_io.timeout_err = tmo_q;

  a_gnt_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(gnt_0_q && gnt_1_q));
  a_valid_is_gnt  : assert property (@(posedge clk) disable iff (!rst_n)
    valid_q == (gnt_0_q || gnt_1_q));
  a_legal_op      : assert property (@(posedge clk) disable iff (!rst_n)
    valid_q |-> (op_q != C_OP_ILLEGAL));

endmodule
`default_nettype wire

// File: tb/tb_coherence_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_coherence_bus_arbiter : scoreboard bench for coherence_bus_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_coherence_bus_arbiter;

  localparam int ADDR_W      = 13;
  localparam int TIMEOUT_CYC = 16;

  typedef struct packed {
    logic              owner;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic clk;
  logic rst_n;

  coherence_bus_arbiter_if #(.ADDR_W(ADDR_W)) bif ();

  coherence_bus_arbiter #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bif)
  );

  int   n_cmp      = 0;
  int   n_err      = 0;
  int   tmo_total  = 0;
  int   cur_len    = 0;
  int   last_len   = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bif.done = 1'b1;
    step();
    bif.done = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bif.gnt_0, bif.gnt_1, bif.bus_valid, bif.bus_op,
                bif.bus_addr, bif.bus_owner, bif.timeout_err});
  endfunction

  function automatic exp_t mk(input logic o, input logic [1:0] op, input logic [ADDR_W-1:0] a);
    exp_t e;
    e.owner = o;
    e.op    = op;
    e.addr  = a;
    return e;
  endfunction

  // Monitor: invariants every cycle, scoreboard pop on each new grant.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      cur_len    = 0;
    end else begin
      check("gnt_excl", 32'(bif.gnt_0 & bif.gnt_1), 32'd0);
      check("valid_eq_gnt", 32'(bif.bus_valid), 32'(bif.gnt_0 | bif.gnt_1));
      if (bif.timeout_err) tmo_total++;
      if (bif.bus_valid) begin
        if (!prev_valid) begin
          cur_len = 1;
          if (sb.size() == 0) begin
            check("sb_unexpected_grant", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("sb_owner", 32'(bif.bus_owner), 32'(e.owner));
            check("sb_op",    32'(bif.bus_op),    32'(e.op));
            check("sb_addr",  32'(bif.bus_addr),  32'(e.addr));
            check("sb_gnt_bit", 32'(e.owner ? bif.gnt_1 : bif.gnt_0), 32'd1);
          end
        end else begin
          cur_len++;
        end
      end else if (prev_valid) begin
        last_len = cur_len;
      end
      prev_valid = bif.bus_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    logic prev_owner;
    int   cnt;
    int   tmo_seen;
    int   last_gnt;
    int   tmo_at;
    int   w;

    rst_n     = 1'b0;
    bif.req_0 = 1'b0; bif.op_0 = 2'b00; bif.addr_0 = '0;
    bif.req_1 = 1'b0; bif.op_1 = 2'b00; bif.addr_1 = '0;
    bif.done  = 1'b0;

    // Reset values, then ten quiet cycles.
    step();
    step();
    check("rst_vals", all_outs(), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_quiet", all_outs(), 32'd0);
    end

    // Single cpu0 request, done three cycles after grant, dead cycle after.
    bif.req_0 = 1'b1; bif.op_0 = 2'b01; bif.addr_0 = 13'h0A5;
    sb.push_back(mk(1'b0, 2'b01, 13'h0A5));
    step();
    check("t2_gnt_lat", 32'({bif.gnt_0, bif.bus_op, bif.bus_addr}), 32'({1'b1, 2'b01, 13'h0A5}));
    bif.req_0 = 1'b0;
    step();
    step();
    pulse_done();
    check("t2_release", 32'({bif.gnt_0, bif.bus_valid}), 32'd0);
    bif.req_0 = 1'b1; bif.op_0 = 2'b01; bif.addr_0 = 13'h1B2;
    sb.push_back(mk(1'b0, 2'b01, 13'h1B2));
    step();
    check("t2_dead_cycle", 32'(bif.gnt_0), 32'd0);
    check("t2_gnt_len", 32'(last_len), 32'd3);
    step();
    check("t2_regrant", 32'(bif.gnt_0), 32'd1);
    bif.req_0 = 1'b0;
    pulse_done();
    step();

    // Fresh reset, both held: strict alternation starting at cpu0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    bif.req_0 = 1'b1; bif.op_0 = 2'b10; bif.addr_0 = 13'h0111;
    bif.req_1 = 1'b1; bif.op_1 = 2'b01; bif.addr_1 = 13'h1FFF;
    for (int k = 0; k < 4; k++)
      sb.push_back((k % 2 == 0) ? mk(1'b0, 2'b10, 13'h0111) : mk(1'b1, 2'b01, 13'h1FFF));
    prev_owner = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!bif.bus_valid && w < 10) begin
        step();
        w++;
      end
      if (!bif.bus_valid) check("t3_wait_grant", 32'd0, 32'd1);
      check("t3_order", 32'(bif.bus_owner), 32'(k % 2));
      if (k > 0) check("t3_no_repeat", 32'(bif.bus_owner != prev_owner), 32'd1);
      prev_owner = bif.bus_owner;
      pulse_done();
    end
    bif.req_0 = 1'b0;
    bif.req_1 = 1'b0;
    step();
    step();

    // done in IDLE has no effect.
    pulse_done();
    check("idle_done_ignored", all_outs(), 32'd0);
    step();

    // Watchdog: cpu1 INVAL with no done.
    bif.req_1 = 1'b1; bif.op_1 = 2'b11; bif.addr_1 = 13'h0C3;
    sb.push_back(mk(1'b1, 2'b11, 13'h0C3));
    step();
    bif.req_1 = 1'b0;
    cnt = 0; tmo_seen = 0; last_gnt = -1; tmo_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (bif.gnt_1) begin
        cnt++;
        last_gnt = i;
      end
      if (bif.timeout_err) begin
        tmo_seen++;
        tmo_at = i;
      end
      step();
    end
    check("t4_gnt_cycles", 32'(cnt), 32'(TIMEOUT_CYC));
    check("t4_tmo_pulses", 32'(tmo_seen), 32'd1);
    check("t4_tmo_align", 32'(tmo_at), 32'(last_gnt + 1));
    check("t4_mon_len", 32'(last_len), 32'(TIMEOUT_CYC));
    bif.req_0 = 1'b1; bif.op_0 = 2'b01; bif.addr_0 = 13'h0A0;
    bif.req_1 = 1'b1; bif.op_1 = 2'b10; bif.addr_1 = 13'h0B0;
    sb.push_back(mk(1'b0, 2'b01, 13'h0A0));
    step();
    check("t4_ptr_cpu0", 32'({bif.gnt_0, bif.gnt_1}), 32'b10);
    bif.req_0 = 1'b0;
    bif.req_1 = 1'b0;
    pulse_done();
    step();
    step();

    // Illegal ops ignored; a legal cpu0 op wins even with the pointer at cpu1.
    bif.req_0 = 1'b1; bif.op_0 = 2'b00; bif.addr_0 = 13'h055;
    bif.req_1 = 1'b1; bif.op_1 = 2'b00; bif.addr_1 = 13'h066;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_illegal", 32'(bif.bus_valid), 32'd0);
    end
    bif.op_0 = 2'b10;
    sb.push_back(mk(1'b0, 2'b10, 13'h055));
    step();
    check("t5_legal_gnt", 32'({bif.gnt_0, bif.gnt_1}), 32'b10);
    bif.req_0 = 1'b0; bif.op_0 = 2'b00;
    bif.req_1 = 1'b0; bif.op_1 = 2'b00;
    pulse_done();
    step();
    step();

    // Asynchronous reset in the middle of a cpu1 transaction.
    bif.req_1 = 1'b1; bif.op_1 = 2'b01; bif.addr_1 = 13'h077;
    sb.push_back(mk(1'b1, 2'b01, 13'h077));
    step();
    check("t6_gnt1", 32'(bif.gnt_1), 32'd1);
    bif.req_1 = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", all_outs(), 32'd0);
    bif.req_0 = 1'b1; bif.op_0 = 2'b11; bif.addr_0 = 13'h0AA;
    bif.req_1 = 1'b1; bif.op_1 = 2'b11; bif.addr_1 = 13'h0BB;
    sb.push_back(mk(1'b0, 2'b11, 13'h0AA));
    step();
    check("t6_in_reset", all_outs(), 32'd0);
    rst_n = 1'b1;
    step();
    check("t6_ptr_reset", 32'({bif.gnt_0, bif.gnt_1}), 32'b10);
    bif.req_0 = 1'b0;
    bif.req_1 = 1'b0;
    pulse_done();
    step();
    step();

    check("tmo_total", 32'(tmo_total), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
